// File: rtl/vga_sync_pkg.sv
// vga_pkg: shared VGA timing constants for the pixel pipeline.
// Holds the default 640x480@60 Hz horizontal/vertical timing, the derived
// totals, the sync polarity and the coordinate width. The renderer and the
// object generators import the same package so every block agrees on timing.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Level driven on hsync/vsync during the sync pulse.
  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int COORD_W = 10;

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if: timing/coordinate bundle produced by vga_sync.
// Signals:
//   p_tick     one-clock pixel enable
//   x, y       current pixel column / line
//   video_on   inside the visible area
//   hsync      horizontal sync (active-low)
//   vsync      vertical sync (active-low)
//   frame_tick one-clock pulse on the last pixel tick of a frame
// Modports: master (timing source), slave (consumers).
interface vga_sync_if;
  import vga_pkg::*;

  logic               p_tick;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               video_on;
  logic               hsync;
  logic               vsync;
  logic               frame_tick;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_tick
  );

endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// pixel_tick_gen: clock-enable divider, one-clock pulse every DIV clocks.
// Also reused for slower enables (e.g. the 1 ms game clock).
// Ports:
//   clk    in  board clock
//   reset  in  synchronous, active-high
//   p_tick out high for one clock when the count reaches DIV-1
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == CNT_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // With DIV = 1 the count sits at its last value even during reset, so the
  // decode is gated by reset to keep the enable low while reset is held.
  assign p_tick = ~reset & (r_div_cnt == CNT_LAST);

endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator (default 640x480@60 Hz).
// Divides the board clock to a pixel enable, runs the x/y pixel counters and
// decodes video_on and the sync pulses. Timing free-runs from reset.
// Ports:
//   clk    in  board clock
//   reset  in  synchronous, active-high
//   vga    master modport of vga_sync_if (p_tick, x, y, video_on, hsync,
//          vsync, frame_tick)
module vga_sync #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic      clk,
  input  logic      reset,
  vga_sync_if.master vga
);
  import vga_pkg::COORD_W;
  import vga_pkg::SYNC_ACTIVE;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               w_p_tick;
  logic [COORD_W-1:0] w_x_nxt;
  logic [COORD_W-1:0] w_y_nxt;

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_video_on;
  logic               r_hsync;
  logic               r_vsync;

  pixel_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (w_p_tick)
  );

  // Next-state counters; y only moves when x wraps.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_p_tick) begin
      if (r_x == H_LAST) begin
        w_x_nxt = '0;
        if (r_y == V_LAST) begin
          w_y_nxt = '0;
        end else begin
          w_y_nxt = r_y + 1'b1;
        end
      end else begin
        w_x_nxt = r_x + 1'b1;
      end
    end
  end

  // Decodes use the next-state counters so the registered flags line up
  // with the x/y registered on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_video_on <= 1'b0;
      r_hsync    <= ~SYNC_ACTIVE;
      r_vsync    <= ~SYNC_ACTIVE;
    end else begin
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_video_on <= (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
      r_hsync    <= ((w_x_nxt >= HS_START) && (w_x_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync    <= ((w_y_nxt >= VS_START) && (w_y_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign vga.p_tick     = w_p_tick;
  assign vga.x          = r_x;
  assign vga.y          = r_y;
  assign vga.video_on   = r_video_on;
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  // w_p_tick is low during reset, so a reset cycle never reports a frame end.
  assign vga.frame_tick = w_p_tick & (r_x == H_LAST) & (r_y == V_LAST);

endmodule
